a2_bridge_seq: RTL and testbench

//  Parametrised sequencer for the 8-to-1 multiplexed bus-bridge CPLD/latch path to the Apple II slot.

---
 rtl/a2_bridge_seq.sv | 363 ++++++++++++++++++++++++++++++++++++
 tb/tb_a2_bridge_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2_bridge_seq.sv
// Sequencer for the 8-to-1 multiplexed Apple II slot bridge: arbitrates address/data/GPIO ops and
// drives sel/rd_n/wr_n/d_oe. Optional A2_BRIDGE_SEQ_STATS_EN adds saturating operation counters.
module a2_bridge_seq #(
    parameter int DATA_WIDTH    = 8,
    parameter int SEL_WIDTH     = 3,
    parameter int ADDR_BYTES    = 2,
    parameter int ADDR_SEL_BASE = 2,
    parameter int DATA_SEL      = 1,
    parameter int GPIO_SEL      = 0,
    parameter int AUX_SEL       = 4,
    parameter int CFG_SEL       = 5,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                    clk_logic_i,
    input  logic                    reset_i,
    input  logic                    req_rd_addr_i,
    input  logic                    req_rd_data_i,
    input  logic                    req_wr_data_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH-1:0]   gpio_out_i,
    input  logic [DATA_WIDTH-1:0]   bridge_d_i,
    output logic [SEL_WIDTH-1:0]    bridge_sel_o,
    output logic                    bridge_rd_n_o,
    output logic                    bridge_wr_n_o,
    output logic [DATA_WIDTH-1:0]   bridge_d_o,
    output logic                    bridge_d_oe_o,
    output logic [8*ADDR_BYTES-1:0] addr_o,
    output logic                    rw_n_o,
    output logic [DATA_WIDTH-1:0]   aux_o,
    output logic                    addr_valid_o,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    data_valid_o,
    output logic [DATA_WIDTH-1:0]   gpio_in_o,
    output logic [DATA_WIDTH-1:0]   cfg_o,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic [15:0]             stat_rd_addr_o,
    output logic [15:0]             stat_rd_data_o,
    output logic [15:0]             stat_wr_data_o,
    output logic [15:0]             stat_overrun_o
);
    localparam int AW    = 8*ADDR_BYTES;
    localparam int LANES = ADDR_BYTES + 2;
    localparam logic [SEL_WIDTH-1:0] GPIO_S = SEL_WIDTH'(GPIO_SEL);
    localparam logic [SEL_WIDTH-1:0] DATA_S = SEL_WIDTH'(DATA_SEL);
    localparam logic [SEL_WIDTH-1:0] AUX_S  = SEL_WIDTH'(AUX_SEL);
    localparam logic [SEL_WIDTH-1:0] CFG_S  = SEL_WIDTH'(CFG_SEL);
    localparam logic [DATA_WIDTH-1:0] ONES  = {DATA_WIDTH{1'b1}};

    typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_RD_ADDR, ST_RD_DATA, ST_WR_DATA, ST_WR_GPIO} state_t;
    typedef enum logic [2:0] {PH_LOAD, PH_SETUP, PH_STROBE, PH_HOLD, PH_READ, PH_CAPT} phase_t;

    state_t state_q, state_d;
    phase_t ph_q, ph_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, wr_data_q, wr_data_d, last_gpio_q, last_gpio_d;
    logic pend_ra_q, pend_ra_d, pend_rd_q, pend_rd_d, pend_wd_q, pend_wd_d, pend_gp_q, pend_gp_d;
    logic prev_idle_q, prev_idle_d, ovr_q, ovr_d, busy_q, busy_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
    logic [DATA_WIDTH-1:0] d_o_q, d_o_d;
    logic [AW-1:0]         addr_sh_q, addr_sh_d, addr_q, addr_d;
    logic rw_sh_q, rw_sh_d, rw_n_q, rw_n_d, addr_valid_q, addr_valid_d, data_valid_q, data_valid_d;
    logic [DATA_WIDTH-1:0] aux_q, aux_d, data_q, data_d, gpio_in_q, gpio_in_d, cfg_q, cfg_d;
    logic disp_ra, disp_rd, disp_wd, disp_gp, gp_set, ovr_ev;

    // Bus outputs are computed from the current step and appear one cycle later, so a lane
    // driven by step k is sampled while the sequencer sits in step k+1.
    // Next-state, bus drive and capture logic.
    always_comb begin
        int k;
        k            = int'(cnt_q);
        state_d      = state_q;
        ph_d         = ph_q;
        cnt_d        = cnt_q;
        wdata_d      = wdata_q;
        last_gpio_d  = last_gpio_q;
        addr_sh_d    = addr_sh_q;
        rw_sh_d      = rw_sh_q;
        addr_d       = addr_q;
        rw_n_d       = rw_n_q;
        aux_d        = aux_q;
        addr_valid_d = 1'b0;
        data_d       = data_q;
        data_valid_d = 1'b0;
        cfg_d        = cfg_q;
        gpio_in_d    = gpio_in_q;
        disp_ra      = 1'b0;
        disp_rd      = 1'b0;
        disp_wd      = 1'b0;
        disp_gp      = 1'b0;
        sel_d        = GPIO_S;
        rd_n_d       = 1'b0;
        wr_n_d       = 1'b1;
        d_o_d        = d_o_q;
        oe_d         = 1'b0;

        if ((state_q == ST_INIT || state_q == ST_WR_DATA || state_q == ST_WR_GPIO) &&
            (ph_q == PH_SETUP || ph_q == PH_STROBE || ph_q == PH_HOLD)) begin
            sel_d  = (state_q == ST_WR_DATA) ? DATA_S : GPIO_S;
            rd_n_d = 1'b1;
            d_o_d  = wdata_q;
            case (ph_q)
                PH_SETUP: begin
                    oe_d = 1'b1;
                    if (cnt_q == 3'(SETUP_CYCLES - 1)) begin
                        ph_d  = PH_STROBE;
                        cnt_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                PH_STROBE: begin
                    oe_d   = 1'b1;
                    wr_n_d = 1'b0;
                    if (cnt_q == 3'(STROBE_CYCLES - 1)) begin
                        ph_d  = PH_HOLD;
                        cnt_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    if (state_q == ST_WR_DATA) begin
                        state_d = ST_IDLE;
                    end else if (state_q == ST_WR_GPIO) begin
                        state_d     = ST_IDLE;
                        last_gpio_d = wdata_q;
                    end else begin
                        ph_d        = PH_READ;
                        last_gpio_d = wdata_q;
                    end
                end
            endcase
        end else begin
            case (state_q)
                ST_INIT: begin
                    case (ph_q)
                        PH_LOAD: begin
                            rd_n_d  = 1'b1;
                            wdata_d = gpio_out_i;
                            ph_d    = PH_SETUP;
                            cnt_d   = 3'd0;
                        end
                        PH_READ: begin
                            sel_d = CFG_S;
                            ph_d  = PH_CAPT;
                        end
                        PH_CAPT: begin
                            cfg_d   = bridge_d_i;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            rd_n_d = 1'b1;
                            ph_d   = PH_LOAD;
                        end
                    endcase
                end
                ST_IDLE: begin
                    if (prev_idle_q) begin
                        gpio_in_d = bridge_d_i;
                    end else begin
                        gpio_in_d = gpio_in_q;
                    end
                    cnt_d = 3'd0;
                    ph_d  = PH_SETUP;
                    if (pend_wd_q) begin
                        state_d = ST_WR_DATA;
                        wdata_d = wr_data_q;
                        disp_wd = 1'b1;
                    end else if (pend_rd_q) begin
                        state_d = ST_RD_DATA;
                        disp_rd = 1'b1;
                    end else if (pend_ra_q) begin
                        state_d = ST_RD_ADDR;
                        disp_ra = 1'b1;
                    end else if (pend_gp_q) begin
                        state_d = ST_WR_GPIO;
                        wdata_d = gpio_out_i;
                        disp_gp = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (k < ADDR_BYTES) begin
                        sel_d = SEL_WIDTH'(ADDR_SEL_BASE + k);
                    end else if (k == ADDR_BYTES) begin
                        sel_d = GPIO_S;
                    end else if (k == ADDR_BYTES + 1) begin
                        sel_d = AUX_S;
                    end else begin
                        sel_d = GPIO_S;
                    end
                    if (k >= 1 && k - 1 < ADDR_BYTES) begin
                        addr_sh_d[8*(k-1) +: 8] = bridge_d_i[7:0];
                    end else if (k - 1 == ADDR_BYTES) begin
                        rw_sh_d = bridge_d_i[0];
                    end else if (k == LANES) begin
                        addr_d       = addr_sh_q;
                        rw_n_d       = rw_sh_q;
                        aux_d        = bridge_d_i;
                        addr_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        addr_sh_d = addr_sh_q;
                    end
                    cnt_d = cnt_q + 3'd1;
                end
                ST_RD_DATA: begin
                    if (cnt_q == 3'd0) begin
                        sel_d = DATA_S;
                        cnt_d = 3'd1;
                    end else begin
                        data_d       = bridge_d_i;
                        data_valid_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d      = (state_d != ST_IDLE);
        prev_idle_d = (state_q == ST_IDLE);
    end

    // Request capture, pending flags and sticky overrun.
    always_comb begin
        ovr_ev    = (req_rd_addr_i & pend_ra_q) | (req_rd_data_i & pend_rd_q) | (req_wr_data_i & pend_wd_q);
        ovr_d     = ovr_q | ovr_ev;
        pend_ra_d = (pend_ra_q & ~disp_ra) | req_rd_addr_i;
        pend_rd_d = (pend_rd_q & ~disp_rd) | req_rd_data_i;
        pend_wd_d = (pend_wd_q & ~disp_wd) | req_wr_data_i;
        // An in-flight GPIO write must not re-arm itself before last_gpio catches up.
        gp_set    = (state_q != ST_INIT) && (state_q != ST_WR_GPIO) && !disp_gp &&
                    (gpio_out_i != last_gpio_q);
        pend_gp_d = (pend_gp_q & ~disp_gp) | gp_set;
        if (req_wr_data_i && !pend_wd_q) begin
            wr_data_d = wr_data_i;
        end else begin
            wr_data_d = wr_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_INIT;
            ph_q         <= PH_LOAD;
            cnt_q        <= 3'd0;
            wdata_q      <= '0;
            wr_data_q    <= '0;
            last_gpio_q  <= ONES;
            pend_ra_q    <= 1'b0;
            pend_rd_q    <= 1'b0;
            pend_wd_q    <= 1'b0;
            pend_gp_q    <= 1'b0;
            prev_idle_q  <= 1'b0;
            ovr_q        <= 1'b0;
            busy_q       <= 1'b1;
            sel_q        <= GPIO_S;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            oe_q         <= 1'b0;
            d_o_q        <= '0;
            addr_sh_q    <= '0;
            rw_sh_q      <= 1'b1;
            addr_q       <= '0;
            rw_n_q       <= 1'b1;
            aux_q        <= '0;
            addr_valid_q <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            gpio_in_q    <= ONES;
            cfg_q        <= ONES;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            cnt_q        <= cnt_d;
            wdata_q      <= wdata_d;
            wr_data_q    <= wr_data_d;
            last_gpio_q  <= last_gpio_d;
            pend_ra_q    <= pend_ra_d;
            pend_rd_q    <= pend_rd_d;
            pend_wd_q    <= pend_wd_d;
            pend_gp_q    <= pend_gp_d;
            prev_idle_q  <= prev_idle_d;
            ovr_q        <= ovr_d;
            busy_q       <= busy_d;
            sel_q        <= sel_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            oe_q         <= oe_d;
            d_o_q        <= d_o_d;
            addr_sh_q    <= addr_sh_d;
            rw_sh_q      <= rw_sh_d;
            addr_q       <= addr_d;
            rw_n_q       <= rw_n_d;
            aux_q        <= aux_d;
            addr_valid_q <= addr_valid_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            gpio_in_q    <= gpio_in_d;
            cfg_q        <= cfg_d;
        end
    end

    assign bridge_sel_o  = sel_q;
    assign bridge_rd_n_o = rd_n_q;
    assign bridge_wr_n_o = wr_n_q;
    assign bridge_d_o    = d_o_q;
    assign bridge_d_oe_o = oe_q;
    assign addr_o        = addr_q;
    assign rw_n_o        = rw_n_q;
    assign aux_o         = aux_q;
    assign addr_valid_o  = addr_valid_q;
    assign data_o        = data_q;
    assign data_valid_o  = data_valid_q;
    assign gpio_in_o     = gpio_in_q;
    assign cfg_o         = cfg_q;
    assign busy_o        = busy_q;
    assign overrun_o     = ovr_q;

`ifdef A2_BRIDGE_SEQ_STATS_EN
    logic [15:0] st_ra_q, st_rd_q, st_wd_q, st_ov_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        if (en && v != 16'hFFFF) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    // Saturating completion and overrun counters.
    always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
            st_ra_q <= 16'd0;
            st_rd_q <= 16'd0;
            st_wd_q <= 16'd0;
            st_ov_q <= 16'd0;
        end else begin
            st_ra_q <= sat_inc(st_ra_q, addr_valid_q);
            st_rd_q <= sat_inc(st_rd_q, data_valid_q);
            st_wd_q <= sat_inc(st_wd_q, (state_q == ST_WR_DATA) && (ph_q == PH_HOLD));
            st_ov_q <= sat_inc(st_ov_q, ovr_ev);
        end
    end

    assign stat_rd_addr_o = st_ra_q;
    assign stat_rd_data_o = st_rd_q;
    assign stat_wr_data_o = st_wd_q;
    assign stat_overrun_o = st_ov_q;
`else
    assign stat_rd_addr_o = 16'd0;
    assign stat_rd_data_o = 16'd0;
    assign stat_wr_data_o = 16'd0;
    assign stat_overrun_o = 16'd0;
`endif
endmodule

// File: tb/tb_a2_bridge_seq.sv
// Self-checking bench for a2_bridge_seq: bridge lane model, write/pulse monitors, directed
// scenarios followed by randomized operations checked against lane-derived expectations.
module tb_a2_bridge_seq;
    localparam int SETUP  = 2;
    localparam int STROBE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_ra, req_rd, req_wd;
    logic [7:0]  wr_data, gpio_out, bridge_d;
    logic [2:0]  sel;
    logic        rd_n, wr_n, oe;
    logic [7:0]  d_o;
    logic [15:0] addr;
    logic        rw_n, av, dv, busy, ovr;
    logic [7:0]  aux, data, gpio_in, cfg;
    logic [15:0] st_ra, st_rd, st_wd, st_ov;

    logic [7:0] lanes [8];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    a2_bridge_seq #(.SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE)) dut (
        .clk_logic_i(clk), .reset_i(rst),
        .req_rd_addr_i(req_ra), .req_rd_data_i(req_rd), .req_wr_data_i(req_wd),
        .wr_data_i(wr_data), .gpio_out_i(gpio_out), .bridge_d_i(bridge_d),
        .bridge_sel_o(sel), .bridge_rd_n_o(rd_n), .bridge_wr_n_o(wr_n),
        .bridge_d_o(d_o), .bridge_d_oe_o(oe),
        .addr_o(addr), .rw_n_o(rw_n), .aux_o(aux), .addr_valid_o(av),
        .data_o(data), .data_valid_o(dv), .gpio_in_o(gpio_in), .cfg_o(cfg),
        .busy_o(busy), .overrun_o(ovr),
        .stat_rd_addr_o(st_ra), .stat_rd_data_o(st_rd),
        .stat_wr_data_o(st_wd), .stat_overrun_o(st_ov)
    );

    // The bridge returns the selected lane while rd_n is low.
    assign bridge_d = (rd_n == 1'b0) ? lanes[sel] : 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: one record per completed write strobe, plus valid-pulse counters.
    logic [2:0] w_sel;
    logic [7:0] w_dat;
    logic       prev_wr_n = 1'b1;
    int low_cnt = 0, oe_cnt = 0, viol = 0, av_cnt = 0, dv_cnt = 0, dv_time = 0;
    logic [2:0] wq_sel [$];
    logic [7:0] wq_dat [$];
    int wq_low [$], wq_oe [$], wq_time [$];

    always @(negedge clk) begin
        if (rst) begin
            low_cnt <= 0;
            oe_cnt  <= 0;
        end else begin
            if (!prev_wr_n && wr_n) begin
                wq_sel.push_back(w_sel);
                wq_dat.push_back(w_dat);
                wq_low.push_back(low_cnt);
                wq_oe.push_back(oe_cnt);
                wq_time.push_back(cyc);
                low_cnt <= 0;
                oe_cnt  <= oe ? 1 : 0;
            end else begin
                if (!wr_n) begin
                    low_cnt <= low_cnt + 1;
                    w_sel   <= sel;
                    w_dat   <= d_o;
                end
                if (oe) oe_cnt <= oe_cnt + 1;
            end
            if ((oe || !wr_n) && !rd_n) viol <= viol + 1;
            if (av) av_cnt <= av_cnt + 1;
            if (dv) begin
                dv_cnt  <= dv_cnt + 1;
                dv_time <= cyc;
            end
        end
        prev_wr_n <= wr_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 4; i++) begin
            @(negedge clk);
            if (!busy) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle"}, quiet >= 4, 1'b1);
    endtask

    task automatic chk_write(input string tag, input logic [2:0] esel, input logic [7:0] edat,
                             output int wtime);
        wtime = -1;
        chk({tag, "_wcount"}, wq_dat.size(), 1);
        if (wq_dat.size() > 0) begin
            chk({tag, "_wsel"}, wq_sel.pop_front(), esel);
            chk({tag, "_wdata"}, wq_dat.pop_front(), edat);
            chk({tag, "_wlow"}, wq_low.pop_front(), STROBE);
            chk({tag, "_woe"}, wq_oe.pop_front(), SETUP + STROBE);
            wtime = wq_time.pop_front();
        end
        wq_sel.delete(); wq_dat.delete(); wq_low.delete(); wq_oe.delete(); wq_time.delete();
    endtask

    task automatic pulse(input int kind);
        if (kind == 0) req_ra = 1'b1;
        else if (kind == 1) req_rd = 1'b1;
        else req_wd = 1'b1;
        @(negedge clk);
        req_ra = 1'b0;
        req_rd = 1'b0;
        req_wd = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sel"}, sel, 3'd0);
        chk({tag, "_strb"}, {rd_n, wr_n, oe}, 3'b110);
        chk({tag, "_do"}, d_o, 8'h00);
        chk({tag, "_addr"}, {addr, rw_n, aux}, {16'h0000, 1'b1, 8'h00});
        chk({tag, "_data"}, {data, av, dv}, {8'h00, 2'b00});
        chk({tag, "_gin_cfg"}, {gpio_in, cfg}, 16'hFFFF);
        chk({tag, "_ovr_busy"}, {ovr, busy}, 2'b01);
    endtask

    initial begin
        int t, av0, dv0, op;
        logic [7:0] cur_gpio, v;
        rst = 1'b1; req_ra = 1'b0; req_rd = 1'b0; req_wd = 1'b0;
        wr_data = 8'h00; gpio_out = 8'hFF; cur_gpio = 8'hFF;
        for (int i = 0; i < 8; i++) lanes[i] = 8'h00;
        lanes[5] = 8'hF7;
        lanes[0] = 8'h5A;
        repeat (3) @(negedge clk);
        chk_reset_state("rst");

        // Release: INIT writes gpio_out to the GPIO lane, then reads config.
        rst = 1'b0;
        wait_idle("init");
        chk("init_cfg", cfg, 8'hF7);
        chk("init_busy", busy, 1'b0);
        chk_write("init", 3'd0, 8'hFF, t);
        chk("idle_gpio_in", gpio_in, 8'h5A);

        // Address op with latency check: request sampled at edge t, first lane at t+2.
        lanes[2] = 8'h34; lanes[3] = 8'h12; lanes[0] = 8'hFE; lanes[4] = 8'h02;
        av0 = av_cnt;
        req_ra = 1'b1;
        @(negedge clk);
        req_ra = 1'b0;
        @(negedge clk);
        chk("ra_lat_t1", {sel, rd_n}, {3'd0, 1'b0});
        @(negedge clk);
        chk("ra_lat_t2", {sel, rd_n}, {3'd2, 1'b0});
        wait_idle("ra");
        chk("ra_pulses", av_cnt - av0, 1);
        chk("ra_addr", addr, 16'h1234);
        chk("ra_rw_aux", {rw_n, aux}, {1'b0, 8'h02});

        // Data write with stretched setup/strobe.
        wr_data = 8'hA5;
        pulse(2);
        wait_idle("wd");
        chk_write("wd", 3'd1, 8'hA5, t);
        chk("gpio_in_fe", gpio_in, 8'hFE);

        // Simultaneous read and write: write wins, read follows, one data_valid.
        lanes[1] = 8'hC3;
        wr_data = 8'h66;
        dv0 = dv_cnt;
        req_rd = 1'b1; req_wd = 1'b1;
        @(negedge clk);
        req_rd = 1'b0; req_wd = 1'b0;
        wait_idle("rw");
        chk("rw_dv", dv_cnt - dv0, 1);
        chk("rw_data", data, 8'hC3);
        chk_write("rw", 3'd1, 8'h66, t);
        chk("rw_order", t < dv_time, 1'b1);

        // Overrun: two address requests while a write holds the bus.
        chk("ovr_clear", ovr, 1'b0);
        wr_data = 8'h11;
        av0 = av_cnt;
        pulse(2);
        pulse(0);
        pulse(0);
        wait_idle("ovr");
        chk("ovr_set", ovr, 1'b1);
        chk("ovr_noqueue", av_cnt - av0, 1);
        chk_write("ovr", 3'd1, 8'h11, t);
        pulse(1);
        wait_idle("ovr2");
        chk("ovr_sticky", ovr, 1'b1);

        // Reset in the middle of an address op.
        pulse(0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        wait_idle("reinit");
        chk("reinit_cfg", cfg, 8'hF7);
        chk_write("reinit", 3'd0, 8'hFF, t);

        // GPIO change triggers exactly one write.
        gpio_out = 8'hFB; cur_gpio = 8'hFB;
        wait_idle("gpio");
        chk_write("gpio", 3'd0, 8'hFB, t);
        repeat (10) @(negedge clk);
        chk("gpio_nochange", wq_dat.size(), 0);

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                lanes[2] = 8'($urandom); lanes[3] = 8'($urandom);
                lanes[0] = 8'($urandom); lanes[4] = 8'($urandom);
                av0 = av_cnt;
                pulse(0);
                wait_idle("rnd_ra");
                chk("rnd_ra_pulse", av_cnt - av0, 1);
                chk("rnd_ra_addr", addr, {lanes[3], lanes[2]});
                chk("rnd_ra_rw_aux", {rw_n, aux}, {lanes[0][0], lanes[4]});
                chk("rnd_gpio_in", gpio_in, lanes[0]);
            end else if (op == 1) begin
                lanes[1] = 8'($urandom);
                dv0 = dv_cnt;
                pulse(1);
                wait_idle("rnd_rd");
                chk("rnd_rd_pulse", dv_cnt - dv0, 1);
                chk("rnd_rd_data", data, lanes[1]);
            end else if (op == 2) begin
                v = 8'($urandom);
                wr_data = v;
                pulse(2);
                wait_idle("rnd_wd");
                chk_write("rnd_wd", 3'd1, v, t);
            end else begin
                v = 8'($urandom);
                if (v == cur_gpio) v = v ^ 8'h01;
                gpio_out = v;
                cur_gpio = v;
                wait_idle("rnd_gp");
                chk_write("rnd_gp", 3'd0, v, t);
            end
        end

        chk("rd_during_write", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
